// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, instruction fields.
package pipe_pkg;

  localparam int XLEN = 32;

  // All-zero word used as the pipeline bubble.
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  // Byte distance between sequential instructions.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Register-specifier fields used by the load-use check.
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // FETCH: a request is issued or in flight.
  // DRAIN: the in-flight request belongs to a squashed path and must be discarded.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (bubble), load and hold controls.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] pc4_d,
  output logic              vld_p1,
  output logic [DATA_W-1:0] instr_p1,
  output logic [DATA_W-1:0] pc4_p1
);

  // Flush beats load; with neither asserted the register holds its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pc4_p1   <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pc4_p1   <= '0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      instr_p1 <= instr_d;
      pc4_p1   <= pc4_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem req/ready handshake, stall hold buffer,
// redirect drain, and the IF/ID register.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt
);

  fetch_state_e    state_p0, state_n;
  logic [XLEN-1:0] pc_p0, pc_n;
  logic [XLEN-1:0] pend_pc_p0, pend_pc_n;
  logic [XLEN-1:0] hold_instr_p0, hold_pc4_p0;
  logic            hold_vld_p0, hold_vld_n;
  logic            hold_wr;
  logic            infl_p0, infl_n;
  logic            run_p0;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_pc;
  logic            complete;
  logic            ifid_load, ifid_flush;
  logic [XLEN-1:0] ifid_instr_d, ifid_pc4_d;

  assign pc_plus4  = pc_p0 + PC_STEP;
  assign redir_pc  = align_word(redirect_pc);
  assign imem_addr = pc_p0;

  // Next-state, PC, hold buffer and IF/ID control for both fetch states.
  always_comb begin
    state_n      = state_p0;
    pc_n         = pc_p0;
    pend_pc_n    = pend_pc_p0;
    hold_vld_n   = hold_vld_p0;
    hold_wr      = 1'b0;
    imem_req     = 1'b0;
    complete     = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr_d = hold_instr_p0;
    ifid_pc4_d   = hold_pc4_p0;

    case (state_p0)
      FETCH: begin
        // A full hold buffer pauses new requests, but never one already in flight.
        imem_req = run_p0 && !(hold_vld_p0 && !infl_p0);
        complete = imem_req && imem_ready;
        if (redirect) begin
          ifid_flush = 1'b1;
          hold_vld_n = 1'b0;
          if (imem_req && !imem_ready) begin
            // Address must stay stable until the old request completes.
            pend_pc_n = redir_pc;
            state_n   = DRAIN;
          end else begin
            pc_n = redir_pc;
          end
        end else begin
          if (complete) begin
            pc_n = pc_plus4;
          end
          if (stall) begin
            if (complete) begin
              hold_wr    = 1'b1;
              hold_vld_n = 1'b1;
            end
          end else if (hold_vld_p0) begin
            // Older held instruction goes first; a same-cycle arrival refills the buffer.
            ifid_load  = 1'b1;
            hold_vld_n = complete;
            hold_wr    = complete;
          end else if (complete) begin
            ifid_load    = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
          end else begin
            ifid_flush = 1'b1;
          end
        end
      end

      DRAIN: begin
        imem_req   = 1'b1;
        ifid_flush = 1'b1;
        hold_vld_n = 1'b0;
        if (redirect) begin
          pend_pc_n = redir_pc;
        end
        if (imem_ready) begin
          pc_n    = redirect ? redir_pc : pend_pc_p0;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase

    infl_n = imem_req && !imem_ready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= FETCH;
    end else begin
      state_p0 <= state_n;
    end
  end

  // PC, hold-valid, in-flight and run flags; run gates the first request until after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0       <= RESET_PC;
      hold_vld_p0 <= 1'b0;
      infl_p0     <= 1'b0;
      run_p0      <= 1'b0;
    end else begin
      pc_p0       <= pc_n;
      hold_vld_p0 <= hold_vld_n;
      infl_p0     <= infl_n;
      run_p0      <= 1'b1;
    end
  end

  // Data-only registers: pending redirect target and held instruction.
  always_ff @(posedge clk) begin
    pend_pc_p0 <= pend_pc_n;
    if (hold_wr) begin
      hold_instr_p0 <= imem_rdata;
      hold_pc4_p0   <= pc_plus4;
    end
  end

  // ---- IF -> ID stage boundary ----
  if_id_reg #(
    .DATA_W (XLEN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_d  (ifid_instr_d),
    .pc4_d    (ifid_pc4_d),
    .vld_p1   (if_id_valid),
    .instr_p1 (if_id_instr),
    .pc4_p1   (if_id_pc4)
  );

  assign if_id_rs = if_id_instr[RS_MSB:RS_LSB];
  assign if_id_rt = if_id_instr[RT_MSB:RT_LSB];

endmodule
